// File: rtl/add_cnt_pkg.sv
// ----------------------------------------------------------------------------
// add_cnt_pkg
//   Shared definitions for the add/count pipeline:
//     cnt_mode_t  - counter mode applied on each accepted operand beat
//                   (UP=0, DOWN=1, HOLD=2, LOAD=3)
//     to_mode()   - maps the raw 2-bit mode port onto cnt_mode_t
// ----------------------------------------------------------------------------
package add_cnt_pkg;

    typedef enum logic [1:0] {
        CNT_UP   = 2'd0,
        CNT_DOWN = 2'd1,
        CNT_HOLD = 2'd2,
        CNT_LOAD = 2'd3
    } cnt_mode_t;

    // All four encodings are legal modes, so the cast is total.
    function automatic cnt_mode_t to_mode(input logic [1:0] raw);
        return cnt_mode_t'(raw);
    endfunction

endpackage : add_cnt_pkg

// File: rtl/add_cnt_counter.sv
// ----------------------------------------------------------------------------
// add_cnt_counter
//   WIDTH-bit wrapping counter that moves only when step_en is high.
//
//   Ports
//     clk      in   rising-edge clock
//     rst      in   asynchronous active-high reset, clears cnt to 0
//     step_en  in   apply 'mode' on this edge (one accepted beat)
//     mode     in   UP +1, DOWN -1, HOLD keep, LOAD take load_val
//     load_val in   value loaded in LOAD mode
//     cnt      out  current counter value (registered)
// ----------------------------------------------------------------------------
module add_cnt_counter
    import add_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             step_en,
    input  cnt_mode_t        mode,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Plain WIDTH-bit add/subtract gives the modulo-2^WIDTH wrap in both
    // directions for free.
    always_comb begin
        cnt_d = cnt_q;
        if (step_en) begin
            case (mode)
                CNT_UP:   cnt_d = cnt_q + ONE;
                CNT_DOWN: cnt_d = cnt_q - ONE;
                CNT_HOLD: cnt_d = cnt_q;
                CNT_LOAD: cnt_d = load_val;
                default:  cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule : add_cnt_counter

// File: rtl/add_cnt_pipe.sv
// ----------------------------------------------------------------------------
// add_cnt_pipe
//   Two-stage valid/ready pipeline computing sum = a + b + cnt_pre, where
//   cnt_pre is the running counter value at the edge that accepts the beat
//   (before the counter applies that beat's mode).
//
//   Stage 1 registers a+b (WIDTH+1 bits) together with cnt_pre; stage 2
//   registers the final WIDTH-bit result. Both stages move together on
//   advance = !out_valid || out_ready, which is also in_ready, so the
//   pipeline sustains one beat per cycle and stalls as a whole.
//
//   Build option
//     ADD_CNT_PAIR_SAT_EN  defined  : full sum kept in WIDTH+2 bits and
//                                     clamped to 2^WIDTH-1 on overflow,
//                                     sat=1 for a clamped result
//                          undefined: sum truncated modulo 2^WIDTH, sat=0
//
//   Ports
//     clk       in   rising-edge clock
//     rst       in   asynchronous active-high reset
//     in_valid  in   operand beat offered
//     in_ready  out  beat accepted when in_valid && in_ready
//     a, b      in   unsigned operands
//     mode      in   counter mode for the accepted beat (UP/DOWN/HOLD/LOAD)
//     load_val  in   counter value used by LOAD
//     out_valid out  result valid
//     out_ready in   result consumed when out_valid && out_ready
//     sum       out  result
//     sat       out  result was clamped (qualified by out_valid)
//     cnt       out  current counter value
// ----------------------------------------------------------------------------
module add_cnt_pipe
    import add_cnt_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             sat,
    output logic [WIDTH-1:0] cnt
);

    // a+b needs WIDTH+1 bits; adding a WIDTH-bit count needs one more.
    localparam int SUM_W = WIDTH + 2;

    logic             advance;
    logic             accept;
    cnt_mode_t        mode_s;
    logic [WIDTH-1:0] cnt_pre;

    logic             vld_p1_q;
    logic             vld_p1_d;
    logic [WIDTH:0]   ab_p1_q;
    logic [WIDTH:0]   ab_p1_d;
    logic [WIDTH-1:0] cnt_p1_q;

    logic [SUM_W-1:0] full_p2;
    logic             vld_p2_q;
    logic             vld_p2_d;
    logic [WIDTH-1:0] sum_p2_q;
    logic [WIDTH-1:0] sum_p2_d;
    logic             sat_p2_q;
    logic             sat_p2_d;

`ifdef ADD_CNT_PAIR_SAT_EN
    localparam logic [WIDTH-1:0] SUM_MAX = '1;

    // Any set bit above WIDTH means the true sum does not fit: clamp.
    function automatic logic [WIDTH:0] sat_clamp(input logic [SUM_W-1:0] full);
        logic [WIDTH:0] res;
        if (full[SUM_W-1:WIDTH] != '0) begin
            res = {1'b1, SUM_MAX};
        end else begin
            res = {1'b0, full[WIDTH-1:0]};
        end
        return res;
    endfunction
`endif

    // Output register empty or being drained: everything may shift.
    assign advance  = !vld_p2_q || out_ready;
    assign in_ready = advance;
    assign accept   = in_valid && advance;
    assign mode_s   = to_mode(mode);

    add_cnt_counter #(
        .WIDTH(WIDTH)
    ) u_counter (
        .clk     (clk),
        .rst     (rst),
        .step_en (accept),
        .mode    (mode_s),
        .load_val(load_val),
        .cnt     (cnt_pre)
    );

    assign cnt = cnt_pre;

    // ---------------- stage 1: operand sum + counter snapshot ----------------
    assign ab_p1_d  = {1'b0, a} + {1'b0, b};
    assign vld_p1_d = advance ? in_valid : vld_p1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q <= 1'b0;
        end else begin
            vld_p1_q <= vld_p1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ab_p1_q  <= ab_p1_d;
            cnt_p1_q <= cnt_pre;
        end
    end

    // ---------------- stage 2: final sum, clamp or wrap ----------------
    assign full_p2 = {1'b0, ab_p1_q} + {2'b00, cnt_p1_q};

`ifdef ADD_CNT_PAIR_SAT_EN
    assign {sat_p2_d, sum_p2_d} = sat_clamp(full_p2);
`else
    logic unused_carry;
    assign unused_carry = ^full_p2[SUM_W-1:WIDTH];
    assign sum_p2_d     = full_p2[WIDTH-1:0];
    assign sat_p2_d     = 1'b0;
`endif

    assign vld_p2_d = advance ? vld_p1_q : vld_p2_q;

    // Result registers only load on a real beat, so a bubble passing
    // through leaves the last result in place rather than garbage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2_q <= 1'b0;
            sum_p2_q <= '0;
            sat_p2_q <= 1'b0;
        end else begin
            vld_p2_q <= vld_p2_d;
            if (advance && vld_p1_q) begin
                sum_p2_q <= sum_p2_d;
                sat_p2_q <= sat_p2_d;
            end
        end
    end

    assign out_valid = vld_p2_q;
    assign sum       = sum_p2_q;
    assign sat       = sat_p2_q;

endmodule : add_cnt_pipe

// File: tb/tb_add_cnt_pipe.sv
`timescale 1ns/1ps
module tb_add_cnt_pipe;
    import add_cnt_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   mode = 2'd0;
    logic [W-1:0] load_val = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         sat;
    logic [W-1:0] cnt;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic         sat;
        logic [W-1:0] sum;
    } exp_t;

    exp_t         q[$];
    logic [W-1:0] m_cnt;

    always #5 clk = ~clk;

    add_cnt_pipe #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .mode     (mode),
        .load_val (load_val),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .sat      (sat),
        .cnt      (cnt)
    );

    // Reference: plain integer arithmetic on the true sum.
    function automatic exp_t model_res(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                       input logic [W-1:0] cc);
        int unsigned full;
        exp_t r;
        full = 32'(aa) + 32'(bb) + 32'(cc);
        r.sat = 1'b0;
        r.sum = W'(full % (1 << W));
`ifdef ADD_CNT_PAIR_SAT_EN
        if (full > (1 << W) - 1) begin
            r.sat = 1'b1;
            r.sum = W'((1 << W) - 1);
        end
`endif
        return r;
    endfunction

    function automatic logic [W-1:0] model_next(input logic [W-1:0] c, input logic [1:0] md,
                                                input logic [W-1:0] lv);
        int unsigned n;
        case (md)
            2'd0:    n = (32'(c) + 1) % (1 << W);
            2'd1:    n = (32'(c) + (1 << W) - 1) % (1 << W);
            2'd2:    n = 32'(c);
            default: n = 32'(lv);
        endcase
        return W'(n);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a = '0;
        b = '0;
        mode = CNT_UP;
        load_val = '0;
        @(negedge clk);
        rst = 1'b0;
        m_cnt = '0;
        q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid = 1'b1;
        mode = CNT_UP;
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        tests++; if (sum !== '0) begin fails++; $display("FAIL reset_sum got=%h exp=00", sum); end
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL reset_sat got=%b exp=0", sat); end
        tests++; if (cnt !== '0) begin fails++; $display("FAIL reset_cnt got=%h exp=00", cnt); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        tests++; if (cnt !== '0) begin fails++; $display("FAIL reset_cnt_held got=%h exp=00", cnt); end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_count_up();
        do_reset();
        in_valid = 1'b1; mode = CNT_UP; a = 8'd3; b = 8'd4; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++; if (cnt !== W'(i)) begin fails++; $display("FAIL up_cnt t=%0d got=%h exp=%h", i, cnt, W'(i)); end
            tests++; if (out_valid !== 1'(i >= 2)) begin fails++; $display("FAIL up_latency t=%0d got=%b exp=%b", i, out_valid, i >= 2); end
            if (i >= 2) begin
                tests++; if (sum !== W'(7 + i - 2)) begin fails++; $display("FAIL up_sum t=%0d got=%h exp=%h", i, sum, W'(7 + i - 2)); end
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_load_wrap();
        logic [W-1:0] exp_sum [3];
        logic [W-1:0] exp_cnt [6];
        exp_sum = '{8'h00, 8'hFF, 8'h00};
        exp_cnt = '{8'h00, 8'hFF, 8'h00, 8'h01, 8'h01, 8'h01};
        do_reset();
        out_ready = 1'b1; a = '0; b = '0;
        for (int i = 0; i < 6; i++) begin
            in_valid = (i < 3);
            mode = (i == 0) ? CNT_LOAD : CNT_UP;
            load_val = 8'hFF;
            #1;
            tests++; if (cnt !== exp_cnt[i]) begin fails++; $display("FAIL wrap_cnt t=%0d got=%h exp=%h", i, cnt, exp_cnt[i]); end
            tests++; if (out_valid !== 1'(i >= 2 && i <= 4)) begin fails++; $display("FAIL wrap_valid t=%0d got=%b", i, out_valid); end
            if (i >= 2 && i <= 4) begin
                tests++; if (sum !== exp_sum[i-2] || sat !== 1'b0) begin fails++; $display("FAIL wrap_sum t=%0d got=%h/%b exp=%h/0", i, sum, sat, exp_sum[i-2]); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_saturation();
        logic [1:0]   md [5];
        logic [W-1:0] lv [5];
        logic [W-1:0] aa [5];
        logic [W-1:0] bb [5];
        logic [W-1:0] pre [6];
        exp_t e;
        exp_t e0;
        md = '{CNT_HOLD, CNT_HOLD, CNT_LOAD, CNT_HOLD, CNT_DOWN};
        lv = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'h00};
        aa = '{8'hF0, 8'h80, 8'h00, 8'hFF, 8'h00};
        bb = '{8'h20, 8'h7F, 8'h00, 8'hFF, 8'h01};
        pre[0] = '0;
        for (int k = 0; k < 5; k++) pre[k+1] = model_next(pre[k], md[k], lv[k]);
`ifdef ADD_CNT_PAIR_SAT_EN
        e0 = '{sat: 1'b1, sum: 8'hFF};
`else
        e0 = '{sat: 1'b0, sum: 8'h10};
`endif
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            in_valid = (i < 5);
            if (i < 5) begin mode = md[i]; load_val = lv[i]; a = aa[i]; b = bb[i]; end
            #1;
            tests++; if (cnt !== pre[i < 5 ? i : 5]) begin fails++; $display("FAIL sat_cnt t=%0d got=%h exp=%h", i, cnt, pre[i < 5 ? i : 5]); end
            if (i >= 2) begin
                e = model_res(aa[i-2], bb[i-2], pre[i-2]);
                tests++; if (out_valid !== 1'b1 || sum !== e.sum || sat !== e.sat) begin fails++; $display("FAIL sat_res t=%0d got=%b/%h/%b exp=1/%h/%b", i, out_valid, sum, sat, e.sum, e.sat); end
            end
            if (i == 2) begin
                tests++; if (sum !== e0.sum || sat !== e0.sat) begin fails++; $display("FAIL sat_f0_20 got=%h/%b exp=%h/%b", sum, sat, e0.sum, e0.sat); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        bit acc, take;
        logic [W-1:0] cnt_at_stall;
        cnt_at_stall = '0;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            in_valid = (i < 10); mode = CNT_UP; load_val = '0;
            a = W'(i * 17); b = W'(i);
            out_ready = !(i >= 3 && i <= 5);
            #1;
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            if (i == 3) begin
                cnt_at_stall = m_cnt;
                tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL stall_valid got=%b exp=1", out_valid); end
            end
            if (i >= 3 && i <= 5) begin
                tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready t=%0d got=%b exp=0", i, in_ready); end
                tests++; if (cnt !== cnt_at_stall) begin fails++; $display("FAIL stall_cnt t=%0d got=%h exp=%h", i, cnt, cnt_at_stall); end
            end
            tests++; if (cnt !== m_cnt) begin fails++; $display("FAIL stall_cnt_model t=%0d got=%h exp=%h", i, cnt, m_cnt); end
            if (out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL stall_extra t=%0d got=%h exp=none", i, sum); end
                else if (sum !== q[0].sum || sat !== q[0].sat) begin fails++; $display("FAIL stall_order t=%0d got=%h/%b exp=%h/%b", i, sum, sat, q[0].sum, q[0].sat); end
            end
            if (take && q.size() > 0) void'(q.pop_front());
            if (acc) begin q.push_back(model_res(a, b, m_cnt)); m_cnt = model_next(m_cnt, mode, load_val); end
            @(negedge clk);
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL stall_lost got=%0d exp=0 pending", q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready = 1'b1; in_valid = 1'b1; mode = CNT_UP; a = 8'd10; b = 8'd10;
        @(negedge clk);
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL mid_full got=%b exp=1", out_valid); end
        rst = 1'b1;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
        tests++; if (cnt !== '0) begin fails++; $display("FAIL mid_cnt got=%h exp=00", cnt); end
        tests++; if (sum !== '0 || sat !== 1'b0) begin fails++; $display("FAIL mid_sum got=%h/%b exp=00/0", sum, sat); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
        #1;
        rst = 1'b0;
        a = 8'd1; b = 8'd1; in_valid = 1'b1; mode = CNT_UP;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0 || cnt !== 8'd1) begin fails++; $display("FAIL mid_after1 got=%b/%h exp=0/01", out_valid, cnt); end
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b1 || sum !== 8'd2 || sat !== 1'b0) begin fails++; $display("FAIL mid_first_beat got=%b/%h exp=1/02", out_valid, sum); end
        @(negedge clk);
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL mid_no_stale got=%b exp=0", out_valid); end
    endtask

    task automatic test_down_hold();
        exp_t e;
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            in_valid = (i < 5);
            mode = (i == 0) ? CNT_DOWN : ((i < 5) ? CNT_HOLD : CNT_UP);
            a = (i == 0) ? 8'd0 : 8'd1;
            b = (i == 0) ? 8'd0 : 8'd2;
            #1;
            tests++; if (cnt !== ((i == 0) ? 8'h00 : 8'hFF)) begin fails++; $display("FAIL dh_cnt t=%0d got=%h", i, cnt); end
            tests++; if (out_valid !== 1'(i >= 2 && i <= 6)) begin fails++; $display("FAIL dh_valid t=%0d got=%b", i, out_valid); end
            if (i >= 2 && i <= 6) begin
                e = (i == 2) ? model_res(8'd0, 8'd0, 8'h00) : model_res(8'd1, 8'd2, 8'hFF);
                tests++; if (sum !== e.sum || sat !== e.sat) begin fails++; $display("FAIL dh_sum t=%0d got=%h/%b exp=%h/%b", i, sum, sat, e.sum, e.sat); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        bit acc, take;
        do_reset();
        for (int i = 0; i < 406; i++) begin
            if (i < 400) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 6);
                mode      = 2'($urandom_range(0, 3));
                load_val  = W'($urandom);
                a         = W'($urandom);
                b         = W'($urandom);
            end else begin
                in_valid = 1'b0; out_ready = 1'b1;
            end
            #1;
            acc = in_valid && in_ready;
            take = out_valid && out_ready;
            tests++; if (in_ready !== (!out_valid || out_ready)) begin fails++; $display("FAIL rnd_in_ready t=%0d got=%b", i, in_ready); end
            tests++; if (cnt !== m_cnt) begin fails++; $display("FAIL rnd_cnt t=%0d got=%h exp=%h", i, cnt, m_cnt); end
            if (out_valid === 1'b1) begin
                tests++;
                if (q.size() == 0) begin fails++; $display("FAIL rnd_extra t=%0d got=%h exp=none", i, sum); end
                else if (sum !== q[0].sum || sat !== q[0].sat) begin fails++; $display("FAIL rnd_res t=%0d got=%h/%b exp=%h/%b", i, sum, sat, q[0].sum, q[0].sat); end
            end
            if (take && q.size() > 0) void'(q.pop_front());
            if (acc) begin q.push_back(model_res(a, b, m_cnt)); m_cnt = model_next(m_cnt, mode, load_val); end
            @(negedge clk);
        end
        tests++; if (q.size() != 0) begin fails++; $display("FAIL rnd_lost got=%0d exp=0 pending", q.size()); end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_load_wrap();
        test_saturation();
        test_stall();
        test_reset_mid();
        test_down_hold();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule : tb_add_cnt_pipe

// File: doc/add_cnt_pipe.md
ADD_CNT_PIPE -- requirements
Module: add_cnt_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data, counter and result width (>=2).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  operand beat offered.
REQ-005 SHALL have port in_ready  output  1  beat accepted when in_valid&&in_ready.
REQ-006 SHALL have ports a, b  input  WIDTH  unsigned operands.
REQ-007 SHALL have port mode  input  2  counter mode, sampled on acceptance: UP=0, DOWN=1, HOLD=2, LOAD=3.
REQ-008 SHALL have port load_val  input  WIDTH  counter value for LOAD.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-011 SHALL have port sum  output  WIDTH  result.
REQ-012 SHALL have port sat  output  1  result clamped (qualified by out_valid).
REQ-013 SHALL have port cnt  output  WIDTH  current counter value.

Function
REQ-014 SHALL compute sum = a + b + cnt_pre, where cnt_pre is the counter value at the accepting edge, before its update.
REQ-015 SHALL be a 2-stage pipeline: stage 1 registers a+b (WIDTH+1 bits) and cnt_pre; stage 2 registers the final sum.
REQ-016 SHALL present the result on out_valid exactly 2 cycles after acceptance when unstalled; throughput is 1 beat/cycle.
REQ-017 SHALL define advance = !out_valid || out_ready; in_ready = advance; both stages shift only when advance=1.
REQ-018 SHALL hold sum, sat and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL update the counter only on an accepted beat: UP +1, DOWN -1, HOLD unchanged, LOAD <= load_val.
REQ-020 SHALL wrap the counter modulo 2^WIDTH in both directions (0xFF+1=0x00, 0x00-1=0xFF for WIDTH=8).
REQ-021 SHALL leave the counter unchanged when in_valid=0 or in_ready=0.
REQ-022 SHALL propagate stage-1 bubbles (in_valid=0) as out_valid=0 without losing stage-2 data.

Reset
REQ-023 SHALL, on rst=1, immediately clear cnt, both stage valids (out_valid=0), sum=0, sat=0; in_ready=1.
REQ-024 SHALL discard in-flight beats on reset mid-operation; the first post-reset accepted beat uses cnt_pre=0.

Configuration
REQ-025 SHALL honour macro ADD_CNT_PAIR_SAT_EN; when defined, the full sum is computed in WIDTH+2 bits, clamped to 2^WIDTH-1 on overflow, with sat=1 for that result.
REQ-026 SHALL, when ADD_CNT_PAIR_SAT_EN is undefined, truncate the sum modulo 2^WIDTH and tie sat to 0.

Structure
REQ-027 SHALL place the mode enum typedef (cnt_mode_t) and the mode constants in package add_cnt_pkg.
REQ-028 SHALL implement the counter as sub-module add_cnt_counter (ports: clk, rst, step_en, mode, load_val, cnt).

Verification (WIDTH=8)
REQ-029 SHALL cover: reset, mode=UP, a=3, b=4, in_valid=1 continuously, out_ready=1 -> sum 7, 8, 9 on cycles 2, 3, 4; cnt 1, 2, 3.
REQ-030 SHALL cover: one LOAD beat with load_val=0xFF, then UP beats with a=b=0 -> sums 0x00 (old cnt), 0xFF, 0x00; counter wraps.
REQ-031 SHALL cover: cnt=0, a=0xF0, b=0x20 -> with macro sum=0xFF, sat=1; without macro sum=0x10, sat=0.
REQ-032 SHALL cover: out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, sum stable, cnt unchanged; order is preserved after release.
REQ-033 SHALL cover: rst pulsed with both stages valid -> out_valid=0 and cnt=0 before the next clk edge; the next beat with a=1, b=1 yields sum 2.
REQ-034 SHALL cover: mode=DOWN from cnt=0 -> cnt=0xFF after one accepted beat; mode=HOLD -> cnt unchanged over 4 beats.
